word_serializer_msb: RTL
========================

// Module: word_serializer_msb
// PURPOSE
//   Upstream feeder for the serial divisible-by-5 detector. Accepts parallel words over a
//   valid/ready handshake and shifts them out MSB-first, one bit per clk. A one-entry holding
//   buffer lets back-to-back words stream with no bubble. Emits first/last framing so the
//   downstream stage can clear its residue per word and sample its result.
// PARAMETERS
//   WIDTH       8   bits per word; legal range 2..32
//   GAP_CYCLES  0   idle cycles (ser_valid=0) inserted after each word's last bit; 0..15
// PORTS
//   clk        in   1      clock, all logic on posedge
//   rst        in   1      reset, synchronous, active-high
//   in_valid   in   1      producer has a word on in_data
//   in_data    in   WIDTH  word to serialize; bit WIDTH-1 is sent first
//   in_ready   out  1      holding buffer empty; word accepted on edge where valid&&ready
//   ser_bit    out  1      serial data bit; 0 whenever ser_valid=0
//   ser_valid  out  1      ser_bit is a payload bit this cycle
//   ser_first  out  1      this bit is the MSB of a word (qualified by ser_valid)
//   ser_last   out  1      this bit is the LSB of a word (qualified by ser_valid)
//   busy       out  1      state!=IDLE or buffer full
// BEHAVIOUR
//   - All outputs registered. Reset values: in_ready=0 during rst, 1 on first cycle after;
//     ser_bit=0, ser_valid=0, ser_first=0, ser_last=0, busy=0. State=IDLE, buffer empty, count=0.
//   - Holding buffer: buf_full set on accept edge, in_ready = !buf_full (registered).
//     Accept and buffer drain never coincide, since in_ready=0 whenever buf_full=1.
//   - FSM states: IDLE, SHIFT, GAP.
//     IDLE : if buf_full -> load shreg<=buf, cnt<=0, clear buf_full, go SHIFT.
//     SHIFT: ser_valid=1, ser_bit=shreg[WIDTH-1], shreg<<=1, cnt++.
//            ser_first = (cnt==0), ser_last = (cnt==WIDTH-1).
//            On the last bit:
//              GAP_CYCLES>0               -> gap_cnt<=0, go GAP;
//              GAP_CYCLES==0 and buf_full -> reload from buffer, stay SHIFT (no bubble);
//              otherwise                  -> IDLE.
//     GAP  : ser_valid=0. When gap_cnt==GAP_CYCLES-1: buf_full ? reload, SHIFT : IDLE.
//   - Latency: word accepted at edge k -> its MSB is on ser_bit with ser_valid=1 in the cycle
//     after edge k+1 (buffer drains at k+1). The LSB follows WIDTH-1 cycles later.
//   - Throughput with GAP_CYCLES=0: one bit per clk sustained. in_ready reasserts the cycle
//     after the buffer drains.
//   - Counters: cnt is clog2(WIDTH) bits and never wraps beyond WIDTH-1; gap_cnt is 4 bits.
//   - in_data is sampled only on the accept edge. Changes while in_ready=0 are ignored.
//   - rst mid-word: the partial word is abandoned and the buffered word is discarded. No
//     ser_last is issued for the aborted word. The downstream stage shares rst.
//   - No downstream backpressure. The consumer must hold its state when ser_valid=0.
// TESTING
//   1 WIDTH=8, single word 8'hA5 -> ser_bit 1,0,1,0,0,1,0,1 on 8 consecutive ser_valid
//     cycles; ser_first on 1st, ser_last on 8th; MSB appears 2 cycles after accept.
//   2 GAP=0, words 8'h0A then 8'h0F offered back-to-back -> 16 contiguous ser_valid cycles;
//     ser_last/ser_first adjacent; in_ready low exactly while buffer holds 8'h0F.
//   3 GAP=2, two words -> exactly 2 cycles of ser_valid=0 between LSB of word 1 and MSB of
//     word 2.
//   4 in_valid held high with 3 words queued during shifting -> only one extra word buffered;
//     in_ready=0 until drain; no word lost or duplicated; total 24 bits in order.
//   5 rst asserted after 3 bits of 8'hFF with 8'h05 buffered -> next cycle all outputs 0,
//     in_ready=1; a new word 8'h14 then serializes cleanly from its MSB.
//   6 Chained to detector (cleared on ser_first): words 8'd10, 8'd13, 8'd0 -> divisible flag
//     after ser_last = 1, 0, 1.

Source files
------------

// File: rtl/word_serializer_msb.sv
// Parallel-to-serial word feeder, MSB first, with first/last framing.
// A one-entry holding buffer lets words stream back-to-back. Every output is a flop whose
// next value is derived from the next-state values, so a word loaded at an edge shows its
// MSB in the very next cycle.
module word_serializer_msb #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             reload;

    logic in_ready_q, in_ready_d;
    logic ser_bit_q, ser_bit_d;
    logic ser_valid_q, ser_valid_d;
    logic ser_first_q, ser_first_d;
    logic ser_last_q, ser_last_d;
    logic busy_q, busy_d;

    // State register plus datapath and output flops; synchronous reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            gap_cnt_q   <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            in_ready_q  <= in_ready_d;
            ser_bit_q   <= ser_bit_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: advance the shifter, time the gap, drain the buffer, accept new words.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        gap_cnt_d  = gap_cnt_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        reload     = 1'b0;

        case (state_q)
            IDLE: begin
                if (buf_full_q) begin
                    reload = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d = 4'd0;
                        state_d   = GAP;
                    end else if (buf_full_q) begin
                        reload = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (buf_full_q) begin
                        reload = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reload) begin
            shreg_d    = buf_q;
            cnt_d      = '0;
            buf_full_d = 1'b0;
            state_d    = SHIFT;
        end

        if (in_valid && in_ready_q) begin
            buf_d      = in_data;
            buf_full_d = 1'b1;
        end
    end

    // Output decode from next-state values so the registered outputs line up with the state.
    always_comb begin
        in_ready_d  = !buf_full_d;
        ser_valid_d = (state_d == SHIFT);
        ser_bit_d   = ser_valid_d && shreg_d[WIDTH-1];
        ser_first_d = ser_valid_d && (cnt_d == '0);
        ser_last_d  = ser_valid_d && (cnt_d == CNT_LAST);
        busy_d      = (state_d != IDLE) || buf_full_d;
    end

    assign in_ready  = in_ready_q;
    assign ser_bit   = ser_bit_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign busy      = busy_q;

endmodule
